// File: rtl/irq_ctrl_pkg.sv
// Shared types for the Lexington machine-level interrupt controller: CSR layout,
// trap codes, FSM states and the default implemented/edge bit masks.
package irq_ctrl_pkg;

  localparam int TRAP_CODE_WIDTH = 5;

  typedef logic [TRAP_CODE_WIDTH-1:0] trap_code_t;

  localparam trap_code_t TRAP_CODE_MSI      = 5'd3;
  localparam trap_code_t TRAP_CODE_MTI      = 5'd7;
  localparam trap_code_t TRAP_CODE_MEI      = 5'd11;
  localparam trap_code_t TRAP_CODE_UART0_RX = 5'd16;
  localparam trap_code_t TRAP_CODE_UART0_TX = 5'd17;
  localparam trap_code_t TRAP_CODE_TIM0     = 5'd18;
  localparam trap_code_t TRAP_CODE_TIM1     = 5'd19;
  localparam trap_code_t TRAP_CODE_GPIOA0   = 5'd20;
  localparam trap_code_t TRAP_CODE_GPIOB0   = 5'd22;
  localparam trap_code_t TRAP_CODE_GPIOC0   = 5'd24;

  localparam logic [31:0] IRQ_IMPL_MASK = 32'h03FF_0888;
  localparam logic [31:0] IRQ_EDGE_MASK = 32'h03FF_0000;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_REQ,
    IRQ_HOLD
  } irq_state_t;

  // mip/mie layout; the platform block occupies the custom range 31:16
  typedef struct packed {
    logic [5:0] rsvd_hi;
    logic [1:0] gpioc;
    logic [1:0] gpiob;
    logic [1:0] gpioa;
    logic       tim1;
    logic       tim0;
    logic       uart0_tx;
    logic       uart0_rx;
    logic [3:0] rsvd3;
    logic       mei;
    logic [2:0] rsvd2;
    logic       mti;
    logic [2:0] rsvd1;
    logic       msi;
    logic [2:0] rsvd0;
  } interrupt_csr_t;

  function automatic logic [31:0] code_onehot(input trap_code_t code);
    return 32'd1 << code;
  endfunction

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Fixed-priority encoder: MEI > MSI > MTI > platform lines, lowest platform code first.
// Purely combinational; valid_o is high whenever any eligible bit is set.
module irq_ctrl_prio_enc
  import irq_ctrl_pkg::*;
(
  input  logic [31:0] eligible_i,
  output logic        valid_o,
  output trap_code_t  code_o
);

  always_comb begin
    valid_o = |eligible_i;
    code_o  = '0;
    // Later assignments override earlier ones, so scan from lowest priority upward
    for (int i = 31; i >= 16; i--) begin
      if (eligible_i[i]) code_o = TRAP_CODE_WIDTH'(i);
    end
    if (eligible_i[TRAP_CODE_MTI]) code_o = TRAP_CODE_MTI;
    if (eligible_i[TRAP_CODE_MSI]) code_o = TRAP_CODE_MSI;
    if (eligible_i[TRAP_CODE_MEI]) code_o = TRAP_CODE_MEI;
  end

endmodule

// File: rtl/irq_ctrl.sv
// Machine interrupt controller: pending capture, masking, priority and trap req/ack.
// IRQ_SYNC_EN adds a 2-flop synchronizer on platform lines 31:16 (two extra cycles).
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter logic [31:0] IMPL_MASK = IRQ_IMPL_MASK,
  parameter logic [31:0] EDGE_MASK = IRQ_EDGE_MASK
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] irq_i,
  input  logic [31:0] mie_i,
  input  logic        gie_i,
  output logic [31:0] mip_o,
  input  logic        clr_we_i,
  input  logic [31:0] clr_mask_i,
  output logic        trap_req_o,
  output logic [4:0]  trap_code_o,
  input  logic        trap_ack_i
);

  localparam logic [31:0] LEVEL_MASK = IMPL_MASK & ~EDGE_MASK;

  logic [31:0]    irq_s;
  logic [31:0]    irq_prev_q;
  interrupt_csr_t pend_q;
  logic [31:0]    pend_d;
  logic [31:0]    rise;
  logic [31:0]    clr_vec;
  logic [31:0]    eligible;
  logic           win_vld;
  trap_code_t     win_code;

  irq_state_t state_q, state_d;
  logic       req_q, req_d;
  trap_code_t code_q, code_d;

`ifdef IRQ_SYNC_EN
  logic [15:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_i[31:16];
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = {sync2_q, irq_i[15:0]};
`else
  assign irq_s = irq_i;
`endif

  assign rise     = irq_s & ~irq_prev_q & EDGE_MASK;
  assign eligible = pend_q & mie_i & IMPL_MASK;

  // Only an acknowledged request consumes its pending bit; a withdrawal leaves it set
  always_comb begin
    clr_vec = clr_we_i ? clr_mask_i : '0;
    if (state_q == IRQ_REQ && trap_ack_i) clr_vec = clr_vec | code_onehot(code_q);
    pend_d = (irq_s & LEVEL_MASK)
           | ((rise | (pend_q & ~clr_vec)) & EDGE_MASK);
    pend_d = pend_d & IMPL_MASK;
  end

  irq_ctrl_prio_enc u_prio_enc (
    .eligible_i (eligible),
    .valid_o    (win_vld),
    .code_o     (win_code)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    code_d  = code_q;
    unique case (state_q)
      IRQ_IDLE: begin
        if (gie_i && win_vld) begin
          state_d = IRQ_REQ;
          req_d   = 1'b1;
          code_d  = win_code;
        end
      end
      IRQ_REQ: begin
        if (trap_ack_i) begin
          state_d = IRQ_HOLD;
          req_d   = 1'b0;
        end else if (!gie_i || !eligible[code_q]) begin
          state_d = IRQ_IDLE;
          req_d   = 1'b0;
        end
      end
      IRQ_HOLD: begin
        state_d = IRQ_IDLE;
      end
      default: begin
        state_d = IRQ_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev_q <= '0;
      pend_q     <= '0;
      state_q    <= IRQ_IDLE;
      req_q      <= 1'b0;
      code_q     <= '0;
    end else begin
      irq_prev_q <= irq_s;
      pend_q     <= pend_d;
      state_q    <= state_d;
      req_q      <= req_d;
      code_q     <= code_d;
    end
  end

  assign mip_o       = pend_q;
  assign trap_req_o  = req_q;
  assign trap_code_o = code_q;

endmodule
